sram_scan_driver: RTL and testbench

SRAM_SCAN_DRIVER -- requirements
Module: sram_scan_driver

---
 rtl/sram_scan_driver.sv | 188 ++++++++++++++++++
 tb/tb_sram_scan_driver.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_scan_driver.sv
// Serial scan driver for an SRAM scan wrapper: pulses the wrapper reset, shifts a
// 64-bit command header, then streams 32-bit write words out or captures read words in.
module sram_scan_driver #(
    parameter int RST_CYCLES = 10,
    parameter int DATA_W     = 32,
    parameter int LEN_W      = 16,
    parameter int RD_LAT     = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [30:0]       cmd_count,
    input  logic [31:0]       cmd_addr,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [DATA_W-1:0] wr_data,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    output logic              scan_rst_n,
    output logic              scan_si,
    input  logic              scan_so,
    output logic              busy,
    output logic              done,
    output logic              err
);

    typedef enum logic [2:0] {
        IDLE, SRST, HDR, WDATA, RWAIT, RDATA, FIN
    } state_t;

    localparam logic [31:0] RST_LAST   = 32'(RST_CYCLES - 1);
    localparam logic [31:0] HDR_LAST   = 32'd63;
    localparam logic [31:0] RWAIT_LAST = 32'((RD_LAT > 0) ? RD_LAT - 1 : 0);

    state_t             state_reg, state_next;
    logic [31:0]        cnt_reg;
    logic [4:0]         bit_reg;
    logic [LEN_W-1:0]   words_reg;
    logic [LEN_W-1:0]   len_reg;
    logic [LEN_W-1:0]   words_inc;
    logic               write_reg;
    logic [63:0]        hdr_reg;
    logic [DATA_W-1:0]  wsr_reg;
    logic [DATA_W-1:0]  rsr_reg;
    logic [DATA_W-1:0]  rd_data_reg;
    logic               rd_valid_reg;
    logic               err_reg;
    logic               armed_reg;
    logic               accept;
    logic               word_end;
    logic               last_word;

    assign accept    = cmd_valid && (state_reg == IDLE);
    assign word_end  = (bit_reg == 5'd31);
    assign words_inc = words_reg + {{(LEN_W-1){1'b0}}, 1'b1};
    assign last_word = (words_inc == len_reg);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:  if (accept) state_next = SRST;
            SRST:  if (cnt_reg == RST_LAST) state_next = HDR;
            HDR: begin
                if (cnt_reg == HDR_LAST) begin
                    if (len_reg == '0)  state_next = FIN;
                    else if (write_reg) state_next = WDATA;
                    else if (RD_LAT > 0) state_next = RWAIT;
                    else                state_next = RDATA;
                end
            end
            WDATA: if (word_end && last_word) state_next = FIN;
            RWAIT: if (cnt_reg == RWAIT_LAST) state_next = RDATA;
            RDATA: if (word_end && last_word) state_next = FIN;
            FIN:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // The first bit of each write word comes straight from wr_data so the word
    // can be consumed in the same cycle wr_ready is offered, leaving no gap.
    always_comb begin
        cmd_ready = rst_n && (state_reg == IDLE);
        wr_ready  = 1'b0;
        busy      = (state_reg != IDLE);
        done      = (state_reg == FIN);
        scan_si   = 1'b0;
        case (state_reg)
            HDR: scan_si = hdr_reg[0];
            WDATA: begin
                if (bit_reg == 5'd0) begin
                    wr_ready = 1'b1;
                    scan_si  = wr_valid & wr_data[0];
                end else begin
                    scan_si = wsr_reg[0];
                end
            end
            default: scan_si = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg      <= '0;
            bit_reg      <= '0;
            words_reg    <= '0;
            len_reg      <= '0;
            write_reg    <= 1'b0;
            hdr_reg      <= '0;
            wsr_reg      <= '0;
            rsr_reg      <= '0;
            rd_data_reg  <= '0;
            rd_valid_reg <= 1'b0;
            err_reg      <= 1'b0;
            armed_reg    <= 1'b0;
        end else begin
            rd_valid_reg <= 1'b0;

            if (state_reg == IDLE || state_next != state_reg) begin
                cnt_reg <= '0;
            end else begin
                cnt_reg <= cnt_reg + 32'd1;
            end

            if (state_reg == WDATA || state_reg == RDATA) begin
                bit_reg <= bit_reg + 5'd1;
                if (word_end) begin
                    words_reg <= words_inc;
                end
            end else begin
                bit_reg <= '0;
            end

            if (accept) begin
                len_reg   <= cmd_len;
                write_reg <= cmd_write;
                hdr_reg   <= {cmd_addr, cmd_count, cmd_write};
                words_reg <= '0;
                err_reg   <= 1'b0;
                armed_reg <= 1'b0;
            end

            // Wrapper reset stays released from the end of SRST until the next accept or rst_n.
            if (state_reg == SRST && state_next == HDR) begin
                armed_reg <= 1'b1;
            end

            if (state_reg == HDR) begin
                hdr_reg <= {1'b0, hdr_reg[63:1]};
            end

            if (state_reg == WDATA) begin
                if (bit_reg == 5'd0) begin
                    wsr_reg <= wr_valid ? (wr_data >> 1) : '0;
                    if (!wr_valid) begin
                        err_reg <= 1'b1;
                    end
                end else begin
                    wsr_reg <= wsr_reg >> 1;
                end
            end

            if (state_reg == RDATA) begin
                rsr_reg <= {scan_so, rsr_reg[DATA_W-1:1]};
                if (word_end) begin
                    rd_data_reg  <= {scan_so, rsr_reg[DATA_W-1:1]};
                    rd_valid_reg <= 1'b1;
                end
            end
        end
    end

    assign scan_rst_n = armed_reg;
    assign rd_valid   = rd_valid_reg;
    assign rd_data    = rd_data_reg;
    assign err        = err_reg;

endmodule

// File: tb/tb_sram_scan_driver.sv
// Scoreboard bench for sram_scan_driver: expected header, write and read words are
// queued per command and compared as the scan stream and rd_valid pulses appear.
module tb_sram_scan_driver;

    localparam int RST_CYCLES = 10;
    localparam int LEN_W      = 16;

    logic             clk;
    logic             rst_n;
    logic             cmd_valid;
    logic             cmd_ready;
    logic             cmd_write;
    logic [30:0]      cmd_count;
    logic [31:0]      cmd_addr;
    logic [LEN_W-1:0] cmd_len;
    logic             wr_valid;
    logic             wr_ready;
    logic [31:0]      wr_data;
    logic             rd_valid;
    logic [31:0]      rd_data;
    logic             scan_rst_n;
    logic             scan_si;
    logic             scan_so;
    logic             busy;
    logic             done;
    logic             err;

    int errors = 0;
    int checks = 0;

    logic [31:0] wdata_mem [0:7];
    logic [31:0] rdata_mem [0:7];
    logic [31:0] exp_wr_q [$];
    logic [31:0] exp_rd_q [$];

    sram_scan_driver #(
        .RST_CYCLES(RST_CYCLES),
        .DATA_W(32),
        .LEN_W(LEN_W),
        .RD_LAT(0)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_write(cmd_write),
        .cmd_count(cmd_count),
        .cmd_addr(cmd_addr),
        .cmd_len(cmd_len),
        .wr_valid(wr_valid),
        .wr_ready(wr_ready),
        .wr_data(wr_data),
        .rd_valid(rd_valid),
        .rd_data(rd_data),
        .scan_rst_n(scan_rst_n),
        .scan_si(scan_si),
        .scan_so(scan_so),
        .busy(busy),
        .done(done),
        .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Issue one command and follow it cycle by cycle; abort_at >= 0 pulses rst_n at that cycle.
    task automatic do_transfer(input logic wr, input logic [30:0] cnt, input logic [31:0] addr,
                               input int len, input int skip_word, input int abort_at,
                               input logic hold, input string name);
        int t, widx, rd_seen, wr_pulses, wr_bad, si_bad, busy_bad, rst_bad, busy_accepts, ds, de;
        logic finished, aborted, saw_wr_ready, exp_err;
        logic [63:0] hdr_cap, hdr_exp;
        logic [31:0] wcap, w, e;
        t = 0; widx = 0; rd_seen = 0; wr_pulses = 0; wr_bad = 0; si_bad = 0;
        busy_bad = 0; rst_bad = 0; busy_accepts = 0;
        finished = 1'b0; aborted = 1'b0; saw_wr_ready = 1'b0;
        hdr_cap = '0; wcap = '0;
        ds = RST_CYCLES + 64;
        de = ds + 32 * len;
        hdr_exp = {addr, cnt, wr};
        exp_err = wr && (skip_word >= 0) && (skip_word < len);
        exp_wr_q.delete();
        exp_rd_q.delete();
        for (int i = 0; i < len; i++) begin
            if (wr) exp_wr_q.push_back((i == skip_word) ? 32'h0 : wdata_mem[i & 7]);
            else    exp_rd_q.push_back(rdata_mem[i & 7]);
        end

        cmd_write = wr;
        cmd_count = cnt;
        cmd_addr  = addr;
        cmd_len   = LEN_W'(len);
        cmd_valid = 1'b1;
        @(negedge clk);
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s accept_ready: cmd_ready=%b required 1", name, cmd_ready);
        end
        @(posedge clk);
        #1;
        if (!hold) cmd_valid = 1'b0;

        while (!finished && t < de + 40) begin
            if (!wr && t >= ds && t < de) begin
                w = rdata_mem[((t - ds) / 32) & 7];
                scan_so = w[(t - ds) % 32];
            end else begin
                scan_so = 1'b0;
            end
            if (wr) begin
                wr_valid = (widx < len) && (widx != skip_word);
                wr_data  = wdata_mem[widx & 7];
            end
            if (t == abort_at) begin
                rst_n = 1'b0;
                #1;
                checks++;
                if ({busy, scan_rst_n, cmd_ready, wr_ready, scan_si, done} !== 6'b0) begin
                    errors++;
                    $display("FAIL %s abort_outputs: busy,srst_n,ready,wr_ready,si,done=%b required 000000",
                             name, {busy, scan_rst_n, cmd_ready, wr_ready, scan_si, done});
                end
                repeat (2) @(posedge clk);
                #1;
                rst_n = 1'b1;
                #1;
                checks++;
                if ({cmd_ready, scan_rst_n, busy, done} !== 4'b1000) begin
                    errors++;
                    $display("FAIL %s abort_release: ready,srst_n,busy,done=%b required 1000",
                             name, {cmd_ready, scan_rst_n, busy, done});
                end
                aborted = 1'b1;
                break;
            end
            @(negedge clk);
            if (t == 0) begin
                checks++;
                if (err !== 1'b0) begin
                    errors++;
                    $display("FAIL %s err_cleared: err=%b required 0", name, err);
                end
            end
            if (scan_rst_n !== ((t < RST_CYCLES) ? 1'b0 : 1'b1)) rst_bad++;
            if (busy !== 1'b1) busy_bad++;
            if (cmd_valid && cmd_ready) busy_accepts++;
            if (t >= RST_CYCLES && t < ds) begin
                hdr_cap[t - RST_CYCLES] = scan_si;
            end else if (wr && t >= ds && t < de) begin
                wcap[(t - ds) % 32] = scan_si;
                if ((t - ds) % 32 == 31) begin
                    checks++;
                    if (exp_wr_q.size() == 0) begin
                        errors++;
                        $display("FAIL %s wr_word: got %08h with nothing expected", name, wcap);
                    end else begin
                        e = exp_wr_q.pop_front();
                        if (wcap !== e) begin
                            errors++;
                            $display("FAIL %s wr_word: shifted %08h required %08h", name, wcap, e);
                        end
                    end
                end
            end else if (scan_si !== 1'b0) begin
                si_bad++;
            end
            saw_wr_ready = wr_ready;
            if (wr_ready === 1'b1) begin
                wr_pulses++;
                if (t < ds || ((t - ds) % 32) != 0) wr_bad++;
            end
            if (rd_valid === 1'b1) begin
                rd_seen++;
                checks++;
                if (exp_rd_q.size() == 0) begin
                    errors++;
                    $display("FAIL %s rd_word: got %08h with nothing expected", name, rd_data);
                end else begin
                    e = exp_rd_q.pop_front();
                    if (rd_data !== e || t != ds + 32 * rd_seen) begin
                        errors++;
                        $display("FAIL %s rd_word: got %08h at cycle %0d required %08h at cycle %0d",
                                 name, rd_data, t, e, ds + 32 * rd_seen);
                    end
                end
            end
            if (done === 1'b1) finished = 1'b1;
            @(posedge clk);
            #1;
            if (wr && saw_wr_ready) widx++;
            if (!finished) t++;
        end

        if (aborted) begin
            exp_wr_q.delete();
            exp_rd_q.delete();
            wr_valid = 1'b0;
            $display("transfer %s: aborted by reset at cycle %0d", name, t);
            return;
        end

        checks++;
        if (!finished || t != de) begin
            errors++;
            $display("FAIL %s done_cycle: done seen=%b at cycle %0d required cycle %0d", name, finished, t, de);
        end
        checks++;
        if (hdr_cap !== hdr_exp) begin
            errors++;
            $display("FAIL %s header: shifted %016h required %016h", name, hdr_cap, hdr_exp);
        end
        checks++;
        if (rst_bad != 0 || si_bad != 0 || busy_bad != 0) begin
            errors++;
            $display("FAIL %s line_levels: bad scan_rst_n=%0d scan_si=%0d busy=%0d cycles required 0",
                     name, rst_bad, si_bad, busy_bad);
        end
        checks++;
        if (busy_accepts != 0) begin
            errors++;
            $display("FAIL %s busy_accept: %0d accepts while busy required 0", name, busy_accepts);
        end
        checks++;
        if (wr_pulses != (wr ? len : 0) || wr_bad != 0 || rd_seen != (wr ? 0 : len)) begin
            errors++;
            $display("FAIL %s handshakes: wr_ready=%0d (misplaced %0d) rd_valid=%0d required %0d/0/%0d",
                     name, wr_pulses, wr_bad, rd_seen, wr ? len : 0, wr ? 0 : len);
        end
        checks++;
        if (exp_wr_q.size() != 0 || exp_rd_q.size() != 0) begin
            errors++;
            $display("FAIL %s scoreboard_left: wr=%0d rd=%0d entries required 0",
                     name, exp_wr_q.size(), exp_rd_q.size());
        end
        checks++;
        if ({err, busy, done, scan_rst_n, cmd_ready} !== {exp_err, 4'b0011}) begin
            errors++;
            $display("FAIL %s after_fin: err,busy,done,srst_n,ready=%b required %b",
                     name, {err, busy, done, scan_rst_n, cmd_ready}, {exp_err, 4'b0011});
        end
        wr_valid = 1'b0;
        $display("transfer %s: write=%b len=%0d done at cycle %0d err=%b", name, wr, len, t, err);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_count = '0; cmd_addr = '0; cmd_len = '0;
        wr_valid = 1'b0; wr_data = '0; scan_so = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({cmd_ready, busy, done, err, scan_rst_n, scan_si, wr_ready, rd_valid} !== 8'b0 || rd_data !== 32'h0) begin
            errors++;
            $display("FAIL reset_state: ready,busy,done,err,srst_n,si,wr_ready,rd_valid=%b rd_data=%08h required all 0",
                     {cmd_ready, busy, done, err, scan_rst_n, scan_si, wr_ready, rd_valid}, rd_data);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        checks++;
        if (cmd_ready !== 1'b1 || scan_rst_n !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: ready=%b srst_n=%b busy=%b required 1 0 0", cmd_ready, scan_rst_n, busy);
        end
        @(posedge clk);
        #1;
        $display("transfer reset: released");
    endtask

    task automatic test_write_basic();
        wdata_mem[0] = 32'h00012117; wdata_mem[1] = 32'h04010113;
        wdata_mem[2] = 32'h00022517; wdata_mem[3] = 32'h03c50513;
        do_transfer(1'b1, 31'h7FFF_FFFF, 32'h0, 4, -1, -1, 1'b0, "write_basic");
    endtask

    task automatic test_read();
        rdata_mem[0] = 32'hDEADBEEF; rdata_mem[1] = 32'h12345678;
        do_transfer(1'b0, 31'h0000_0002, 32'h8000_1234, 2, -1, -1, 1'b0, "read_two");
    endtask

    task automatic test_underrun();
        wdata_mem[0] = 32'hA5A5_0F0F; wdata_mem[1] = 32'hFFFF_FFFF; wdata_mem[2] = 32'h8000_0001;
        do_transfer(1'b1, 31'h1234_5678, 32'hCAFE_F00D, 3, 1, -1, 1'b0, "write_underrun");
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (err !== 1'b1) begin
            errors++;
            $display("FAIL underrun_sticky: err=%b required 1", err);
        end
    endtask

    task automatic test_header_only();
        do_transfer(1'b1, 31'h5555_5555, 32'h0F0F_F0F0, 0, -1, -1, 1'b0, "hdr_only_write");
        do_transfer(1'b0, 31'h0000_0001, 32'hFFFF_FFFE, 0, -1, -1, 1'b0, "hdr_only_read");
    endtask

    task automatic test_abort();
        wdata_mem[0] = 32'h1111_2222; wdata_mem[1] = 32'h3333_4444;
        wdata_mem[2] = 32'h5555_6666; wdata_mem[3] = 32'h7777_8888;
        do_transfer(1'b1, 31'h0000_0003, 32'h0000_0040, 4, -1, RST_CYCLES + 64 + 40, 1'b0, "write_abort");
        rdata_mem[0] = 32'h0BAD_F00D;
        do_transfer(1'b0, 31'h0000_0000, 32'h0000_0100, 1, -1, -1, 1'b0, "read_after_abort");
    endtask

    task automatic test_back_to_back();
        wdata_mem[0] = 32'h8765_4321;
        do_transfer(1'b1, 31'h0000_0007, 32'h0000_0010, 1, -1, -1, 1'b1, "b2b_first_held");
        rdata_mem[0] = 32'hFFFF_0000; rdata_mem[1] = 32'h0000_FFFF;
        do_transfer(1'b0, 31'h0000_0009, 32'h0000_0020, 2, -1, -1, 1'b0, "b2b_second");
    endtask

    initial begin
        test_reset();
        test_write_basic();
        test_read();
        test_underrun();
        test_header_only();
        test_abort();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
